apb_master_arbiter: RTL
=======================

// Module: apb_master_arbiter
// PURPOSE
//  Two-requester APB master for the multi-cycle RV32I SoC. Requester 0 is the CPU data port
//  (transfer/ready handshake from the control unit's S_MEM/L_MEM states); requester 1 is the
//  DMA or debug port. Round-robin arbitration, address decode to NUM_SLV slaves, APB SETUP/ACCESS
//  sequencing, and ready/rdata/err return to the granted requester.
// PARAMETERS
//  ADDR_W       32             address width
//  DATA_W       32             data width
//  NUM_SLV      4              APB slaves, 1..16, each a 4 KB window
//  SLV_BASE     32'h1000_0000  base of the APB region; bits [15:0] must be 0
//  TIMEOUT_CYC  255            ACCESS-phase cycle limit (APB_TIMEOUT_EN only)
// PORTS
//  clk          in   1               system clock
//  reset        in   1               synchronous, active-high reset
//  mN_transfer  in   1               N=0,1; request, held high until mN_ready
//  mN_write     in   1               1 = write, 0 = read
//  mN_addr      in   ADDR_W          byte address
//  mN_wdata     in   DATA_W          write data
//  mN_strb      in   DATA_W/8        byte strobes (writes)
//  mN_ready     out  1               one-cycle completion pulse
//  mN_rdata     out  DATA_W          read data, valid with mN_ready
//  mN_err       out  1               error flag, valid with mN_ready
//  PADDR        out  ADDR_W          APB address
//  PWDATA       out  DATA_W          APB write data
//  PWRITE       out  1               APB direction
//  PSTRB        out  DATA_W/8        APB strobes (forced 0 on reads)
//  PENABLE      out  1               APB enable
//  PSEL         out  NUM_SLV         one-hot slave select
//  PRDATA       in   NUM_SLV*DATA_W  slave read data, slave k at [k*DATA_W +: DATA_W]
//  PREADY       in   NUM_SLV         per-slave ready
// BEHAVIOUR
//  - FSM states: IDLE, SETUP, ACCESS, ERR. Reset (sync) -> IDLE; all outputs 0; last_grant=1,
//    so m0 wins the first tie. A reset mid-transfer drops PSEL/PENABLE in the next cycle.
//  - IDLE: sample mN_transfer. If only one requester is high, grant it. If both are high, grant
//    the one != last_grant. Latch addr/wdata/strb/write and grant; update last_grant.
//    Mapped address -> SETUP. Unmapped address -> ERR.
//  - Mapped address: addr[31:16]==SLV_BASE[31:16] and addr[15:12]<NUM_SLV; slave idx=addr[15:12].
//  - SETUP: PSEL[idx]=1, PENABLE=0, P* driven from latched values -> ACCESS unconditionally.
//  - ACCESS: PSEL[idx]=1, PENABLE=1. Wait states are unbounded while PREADY[idx]=0.
//    When PREADY[idx]=1: combinational mG_ready=1, mG_rdata=PRDATA slice (0 on writes),
//    mG_err=0 -> IDLE.
//  - ERR: one cycle, no PSEL; mG_ready=1, mG_err=1, mG_rdata=0 -> IDLE.
//  - Latency: transfer seen in IDLE at cycle 0 -> SETUP at 1 -> ready at 2 (zero-wait slave).
//  - The cycle after ready is always IDLE. A requester must drop transfer after ready; a re-raise
//    is a new request.
//  - The non-granted requester sees ready/err/rdata = 0. PADDR/PWDATA hold their latched values
//    in IDLE; PSEL/PENABLE are 0 in IDLE.
//  - Back-to-back: both requesters held high alternate grants m0,m1,m0,... with 3 cycles per
//    transfer at zero wait.
// CONFIGURATION
//  APB_TIMEOUT_EN defined:
//   - 8-bit wait counter, cleared on SETUP entry and incremented each ACCESS cycle without PREADY.
//   - When it reaches TIMEOUT_CYC: drop PSEL/PENABLE, pulse mG_ready with mG_err=1, rdata=0 -> IDLE.
//  APB_TIMEOUT_EN undefined:
//   - No counter; ACCESS waits forever. mN_err is set only by ERR (decode miss).
// TESTING
//  1. m0 write 0x1000_1004, data 0xDEAD_BEEF, strb 4'hF, zero-wait slave1 -> PSEL=4'b0010;
//     SETUP cycle 1, ACCESS cycle 2, m0_ready cycle 2, err=0.
//  2. m1 read 0x1000_3000, slave3 PREADY low for 3 cycles, PRDATA=0x1234_5678 -> m1_ready on
//     ACCESS cycle 4, rdata=0x1234_5678, PSTRB=0.
//  3. m0 and m1 both high continuously from reset -> grant order m0,m1,m0,m1; no cycle with
//     two readies.
//  4. m0 read 0x2000_0000 (unmapped) -> PSEL never set; m0_ready=1, m0_err=1, rdata=0 at cycle 1.
//  5. Reset asserted during ACCESS with PREADY low -> next cycle IDLE, PSEL=0, PENABLE=0;
//     after reset, m0 wins a tie.
//  6. APB_TIMEOUT_EN with TIMEOUT_CYC=8, slave never ready -> ready+err after 8 ACCESS cycles,
//     then IDLE.

Source files
------------

// File: rtl/apb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_arbiter
// Purpose  : Two-requester APB master. Round-robin arbitration between
//            requester 0 (CPU data port) and requester 1 (DMA/debug port),
//            4 KB-window address decode onto NUM_SLV slaves, APB SETUP/ACCESS
//            sequencing, and ready/rdata/err return to the granted requester.
// Ports    : clk, reset                  - clock, synchronous active-high reset
//            mN_transfer/write/addr/
//            wdata/strb (N=0,1)          - request side, held until mN_ready
//            mN_ready/rdata/err          - one-cycle completion to requester N
//            PADDR/PWDATA/PWRITE/PSTRB/
//            PENABLE/PSEL                - APB master outputs
//            PRDATA/PREADY               - per-slave APB returns
// Options  : APB_TIMEOUT_EN - bounds the ACCESS phase to TIMEOUT_CYC wait
//            cycles, then completes the transfer with an error.
// Revision : 1.0 - initial release
// ============================================================================
module apb_master_arbiter #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                NUM_SLV     = 4,
  parameter logic [ADDR_W-1:0] SLV_BASE    = 32'h1000_0000,
  parameter int                TIMEOUT_CYC = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      m0_transfer,
  input  logic                      m0_write,
  input  logic [ADDR_W-1:0]         m0_addr,
  input  logic [DATA_W-1:0]         m0_wdata,
  input  logic [DATA_W/8-1:0]       m0_strb,
  output logic                      m0_ready,
  output logic [DATA_W-1:0]         m0_rdata,
  output logic                      m0_err,
  input  logic                      m1_transfer,
  input  logic                      m1_write,
  input  logic [ADDR_W-1:0]         m1_addr,
  input  logic [DATA_W-1:0]         m1_wdata,
  input  logic [DATA_W/8-1:0]       m1_strb,
  output logic                      m1_ready,
  output logic [DATA_W-1:0]         m1_rdata,
  output logic                      m1_err,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  output logic                      PWRITE,
  output logic [DATA_W/8-1:0]       PSTRB,
  output logic                      PENABLE,
  output logic [NUM_SLV-1:0]        PSEL,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PREADY
);

  localparam int         STRB_W    = DATA_W / 8;
  localparam logic [4:0] C_NUM_SLV = NUM_SLV[4:0];

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_ERR    = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                grant_q, grant_d;
  logic                last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   strb_q, strb_d;
  logic                write_q, write_d;

  // Requester selection: on a tie the requester that did not win last time
  // is picked; a lone requester always wins.
  logic                w_pick;
  logic [ADDR_W-1:0]   w_req_addr;
  logic [DATA_W-1:0]   w_req_wdata;
  logic [STRB_W-1:0]   w_req_strb;
  logic                w_req_write;
  logic                w_hit;

  assign w_pick      = m1_transfer & (~m0_transfer | ~last_grant_q);
  assign w_req_addr  = w_pick ? m1_addr  : m0_addr;
  assign w_req_wdata = w_pick ? m1_wdata : m0_wdata;
  assign w_req_strb  = w_pick ? m1_strb  : m0_strb;
  assign w_req_write = w_pick ? m1_write : m0_write;
  assign w_hit       = (w_req_addr[ADDR_W-1:16] == SLV_BASE[ADDR_W-1:16]) &&
                       ({1'b0, w_req_addr[15:12]} < C_NUM_SLV);

  // Slave-side mux driven from the latched address; only meaningful while a
  // mapped transfer is in flight, which guarantees the index is in range.
  logic [NUM_SLV-1:0]  w_sel;
  logic [DATA_W-1:0]   w_slv_rdata;
  logic                w_slv_ready;

  always_comb begin
    w_sel       = '0;
    w_slv_rdata = '0;
    w_slv_ready = 1'b0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (addr_q[15:12] == k[3:0]) begin
        w_sel[k]    = 1'b1;
        w_slv_rdata = PRDATA[k*DATA_W +: DATA_W];
        w_slv_ready = PREADY[k];
      end
    end
  end

  logic w_timeout;

`ifdef APB_TIMEOUT_EN
  localparam logic [7:0] C_TIMEOUT = TIMEOUT_CYC[7:0];
  logic [7:0] cnt_q, cnt_d;

  // Counts ACCESS cycles without PREADY; held at zero outside ACCESS so it
  // starts clean on every SETUP entry.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q != S_ACCESS) begin
      cnt_d = '0;
    end else if (!w_timeout && !w_slv_ready) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign w_timeout = (cnt_q == C_TIMEOUT);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYC == 0);
  assign w_timeout        = 1'b0;
`endif

  logic              w_psel_en;
  logic              w_penable;
  logic              w_done;
  logic              w_err;
  logic [DATA_W-1:0] w_rdata;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    strb_d       = strb_q;
    write_d      = write_q;
    w_psel_en    = 1'b0;
    w_penable    = 1'b0;
    w_done       = 1'b0;
    w_err        = 1'b0;
    w_rdata      = '0;
    case (state_q)
      S_IDLE: begin
        if (m0_transfer || m1_transfer) begin
          grant_d      = w_pick;
          last_grant_d = w_pick;
          addr_d       = w_req_addr;
          wdata_d      = w_req_wdata;
          strb_d       = w_req_strb;
          write_d      = w_req_write;
          state_d      = w_hit ? S_SETUP : S_ERR;
        end
      end
      S_SETUP: begin
        w_psel_en = 1'b1;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        if (w_timeout) begin
          // Bus is released in the same cycle the error is reported.
          w_done  = 1'b1;
          w_err   = 1'b1;
          state_d = S_IDLE;
        end else begin
          w_psel_en = 1'b1;
          w_penable = 1'b1;
          if (w_slv_ready) begin
            w_done  = 1'b1;
            w_rdata = write_q ? '0 : w_slv_rdata;
            state_d = S_IDLE;
          end
        end
      end
      S_ERR: begin
        w_done  = 1'b1;
        w_err   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      strb_q       <= '0;
      write_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      strb_q       <= strb_d;
      write_q      <= write_d;
    end
  end

  assign PADDR    = addr_q;
  assign PWDATA   = wdata_q;
  assign PWRITE   = write_q;
  assign PSTRB    = write_q ? strb_q : '0;
  assign PENABLE  = w_penable;
  assign PSEL     = w_psel_en ? w_sel : '0;

  assign m0_ready = w_done & ~grant_q;
  assign m0_err   = w_err  & ~grant_q;
  assign m0_rdata = grant_q ? '0 : w_rdata;
  assign m1_ready = w_done & grant_q;
  assign m1_err   = w_err  & grant_q;
  assign m1_rdata = grant_q ? w_rdata : '0;

endmodule
`default_nettype wire
